// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the i2c_slave register-access target.
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers, optional 3-sample majority filter
// (I2C_SLAVE_GLITCH_FILTER_EN) and edge / START / STOP detection.
module i2c_line_sync
  import i2c_slave_pkg::*;
#(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_level,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SyncStages-1:0] scl_sync;
  logic [SyncStages-1:0] sda_sync;
  logic                  scl_f;
  logic                  sda_f;
  logic                  scl_q;
  logic                  sda_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SyncStages-2:0], scl};
      sda_sync <= {sda_sync[SyncStages-2:0], sda};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [2:0] scl_hist;
  logic [2:0] sda_hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_hist <= '1;
      sda_hist <= '1;
    end else begin
      scl_hist <= {scl_hist[1:0], scl_sync[SyncStages-1]};
      sda_hist <= {sda_hist[1:0], sda_sync[SyncStages-1]};
    end
  end

  assign scl_f = maj3(scl_hist);
  assign sda_f = maj3(sda_hist);
`else
  assign scl_f = scl_sync[SyncStages-1];
  assign sda_f = sda_sync[SyncStages-1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  assign sda_level = sda_f;
  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start     = scl_f & scl_q & sda_q & ~sda_f;
  assign stop      = scl_f & scl_q & ~sda_q & sda_f;

endmodule

// File: rtl/i2c_slave.sv
// I2C target exposing an 8-bit register pointer with auto-increment.
// Define I2C_SLAVE_GLITCH_FILTER_EN to enable the SCL/SDA majority filter.
module i2c_slave
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0]  SlaveAddress = 7'h50,
  parameter int unsigned SyncStages   = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe_n,
  output logic       o_wr_valid,
  output logic       o_rd_req,
  output logic [7:0] o_addr,
  output logic [7:0] o_wdata,
  input  logic [7:0] i_rdata,
  output logic       o_busy
);

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] rx_byte;
  logic       rw;
  logic       rd_pend;
  logic       sda_level;
  logic       scl_rise;
  logic       scl_fall;
  logic       start;
  logic       stop;

  i2c_line_sync #(
    .SyncStages(SyncStages)
  ) u_line_sync (
    .clk      (i_clk),
    .rst      (i_rst),
    .scl      (i_scl),
    .sda      (i_sda),
    .sda_level(sda_level),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  assign rx_byte = {shreg[6:0], sda_level};

  // ACK phases are left on the ACK-bit rise, so a read fetch (rd_req, then
  // load) completes while SCL is still high and the MSB goes out on the fall.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      rw         <= 1'b0;
      rd_pend    <= 1'b0;
      o_sda_oe_n <= NACK;
      o_wr_valid <= 1'b0;
      o_rd_req   <= 1'b0;
      o_addr     <= '0;
      o_wdata    <= '0;
      o_busy     <= 1'b0;
    end else begin
      o_wr_valid <= 1'b0;
      o_rd_req   <= 1'b0;
      rd_pend    <= o_rd_req;
      if (o_wr_valid) o_addr <= o_addr + 8'd1;
      if (rd_pend) shreg <= i_rdata;

      if (stop) begin
        state      <= IDLE;
        o_sda_oe_n <= NACK;
        o_busy     <= 1'b0;
      end else if (start) begin
        state   <= ADDR;
        bit_cnt <= '0;
      end else if (scl_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        case (state)
          ADDR: begin
            shreg <= rx_byte;
            if (bit_cnt == 3'd7) begin
              if (rx_byte[7:1] == SlaveAddress) begin
                state  <= ADDR_ACK;
                rw     <= rx_byte[0];
                o_busy <= 1'b1;
              end else begin
                state <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            bit_cnt <= '0;
            if (rw) begin
              state    <= RD_DATA;
              o_rd_req <= 1'b1;
            end else begin
              state <= PTR;
            end
          end
          PTR: begin
            shreg <= rx_byte;
            if (bit_cnt == 3'd7) begin
              o_addr <= rx_byte;
              state  <= PTR_ACK;
            end
          end
          PTR_ACK, WR_ACK: begin
            bit_cnt <= '0;
            state   <= WR_DATA;
          end
          WR_DATA: begin
            shreg <= rx_byte;
            if (bit_cnt == 3'd7) begin
              o_wdata    <= rx_byte;
              o_wr_valid <= 1'b1;
              state      <= WR_ACK;
            end
          end
          RD_DATA: begin
            if (bit_cnt == 3'd7) state <= RD_ACK;
          end
          RD_ACK: begin
            bit_cnt <= '0;
            if (sda_level == ACK) begin
              o_addr   <= o_addr + 8'd1;
              o_rd_req <= 1'b1;
              state    <= RD_DATA;
            end else begin
              state <= IGNORE;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ADDR_ACK, PTR_ACK, WR_ACK: o_sda_oe_n <= ACK;
          RD_DATA: begin
            o_sda_oe_n <= shreg[7];
            shreg      <= {shreg[6:0], 1'b1};
          end
          default: o_sda_oe_n <= NACK;
        endcase
      end
    end
  end

endmodule
